fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 126 ++++++++++++
 tb/tb_fetch_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the pc, issues one fetch at a time,
// holds each fetched word for decode, and follows redirects.
//
// Ports:
//   clk, reset        - clock, async active-high reset
//   halt              - blocks issue of new fetch requests
//   imem_req_*        - fetch request (valid/ready, addr = pc)
//   imem_resp_*       - fetch response (valid, data)
//   redirect_*        - pc change request (target low bits dropped)
//   out_*             - fetched instr/pc to decode (valid/ready)
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] RV = RESET_VECTOR & ~32'h3;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic        drop;
  logic        drop_nxt;

  logic [31:0] redir_tgt;
  logic        req_fire;
  logic        resp_take;

  assign redir_tgt = redirect_pc & ~32'h3;
  assign req_fire  = imem_req_valid && imem_req_ready;

  // A response is kept only if it belongs to the current pc:
  // no pending drop and no redirect arriving in the same cycle.
  assign resp_take = (state == S_WAIT) && imem_resp_valid &&
                     !drop && !redirect_valid;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_REQ;
      pc    <= RV;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      drop  <= drop_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    case (state)
      S_REQ: begin
        if (req_fire) begin
          state_nxt = S_WAIT;
          // The in-flight word is for the old pc.
          drop_nxt  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          state_nxt = resp_take ? S_HOLD : S_REQ;
          drop_nxt  = 1'b0;
        end else if (redirect_valid) begin
          drop_nxt  = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready || redirect_valid) begin
          state_nxt = S_REQ;
          pc_nxt    = pc + 32'd4;
        end
      end
      default: begin
        state_nxt = S_REQ;
        drop_nxt  = 1'b0;
      end
    endcase
    // Redirect overrides the sequential increment everywhere.
    if (redirect_valid) begin
      pc_nxt = redir_tgt;
    end
  end

  // Output logic
  always_comb begin
    imem_req_valid = (state == S_REQ) && !halt && !reset;
    imem_req_addr  = pc;
    out_valid      = (state == S_HOLD);
  end

  // Fetched word / pc holding registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_instr <= 32'h0;
      out_pc    <= 32'h0;
    end else if (resp_take) begin
      out_instr <= imem_resp_data;
      out_pc    <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector tables
// on two instances plus a randomized run against a fetch-stream model.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        halt;
  logic        rq_valid;
  logic        rq_ready;
  logic [31:0] rq_addr;
  logic        rs_valid;
  logic [31:0] rs_data;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;

  logic        reset_b;
  logic        halt_b;
  logic        rq_valid_b;
  logic        rq_ready_b;
  logic [31:0] rq_addr_b;
  logic        rs_valid_b;
  logic [31:0] rs_data_b;
  logic        rd_valid_b;
  logic [31:0] rd_pc_b;
  logic        o_valid_b;
  logic        o_ready_b;
  logic [31:0] o_instr_b;
  logic [31:0] o_pc_b;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_sequencer u_dut (
    .clk             (clk),
    .reset           (reset),
    .halt            (halt),
    .imem_req_valid  (rq_valid),
    .imem_req_ready  (rq_ready),
    .imem_req_addr   (rq_addr),
    .imem_resp_valid (rs_valid),
    .imem_resp_data  (rs_data),
    .redirect_valid  (rd_valid),
    .redirect_pc     (rd_pc),
    .out_valid       (o_valid),
    .out_ready       (o_ready),
    .out_instr       (o_instr),
    .out_pc          (o_pc)
  );

  fetch_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) u_dut_b (
    .clk             (clk),
    .reset           (reset_b),
    .halt            (halt_b),
    .imem_req_valid  (rq_valid_b),
    .imem_req_ready  (rq_ready_b),
    .imem_req_addr   (rq_addr_b),
    .imem_resp_valid (rs_valid_b),
    .imem_resp_data  (rs_data_b),
    .redirect_valid  (rd_valid_b),
    .redirect_pc     (rd_pc_b),
    .out_valid       (o_valid_b),
    .out_ready       (o_ready_b),
    .out_instr       (o_instr_b),
    .out_pc          (o_pc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        h;
    logic        rdy;
    logic        sv;
    logic [31:0] sd;
    logic        dv;
    logic [31:0] dp;
    logic        ordy;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_opc;
    logic [31:0] e_oin;
  } vec_t;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  function automatic vec_t mk(
    input logic h, input logic rdy, input logic sv,
    input logic [31:0] sd, input logic dv,
    input logic [31:0] dp, input logic ordy,
    input logic erv, input logic [31:0] ea,
    input logic eov, input logic [31:0] eop
  );
    vec_t v;
    v.h = h; v.rdy = rdy; v.sv = sv; v.sd = sd;
    v.dv = dv; v.dp = dp; v.ordy = ordy;
    v.e_rqv = erv; v.e_addr = ea;
    v.e_ov = eov; v.e_opc = eop; v.e_oin = dat(eop);
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  vec_t t0[$];
  vec_t t1[$];

  // random-run model state
  logic        outst;
  int          lat;
  logic [31:0] oaddr;
  logic [31:0] exp_pc;
  logic        p_rd;
  logic        p_hold;
  logic [31:0] p_opc;
  logic [31:0] p_oin;
  logic        p_rqw;
  logic [31:0] p_addr;
  int          deliv;

  initial begin
    // ---- directed table for RESET_VECTOR = 0 ----
    t0.push_back(mk(0,1,0,0,0,0,1, 1,32'h0,0,0));
    t0.push_back(mk(0,1,1,dat(32'h0),0,0,1, 0,0,0,0));
    t0.push_back(mk(0,1,0,0,0,0,1, 0,0,1,32'h0));
    t0.push_back(mk(0,1,0,0,0,0,1, 1,32'h4,0,0));
    t0.push_back(mk(0,1,1,dat(32'h4),0,0,1, 0,0,0,0));
    t0.push_back(mk(0,1,0,0,0,0,1, 0,0,1,32'h4));
    t0.push_back(mk(0,1,0,0,0,0,1, 1,32'h8,0,0));
    t0.push_back(mk(0,1,1,dat(32'h8),0,0,1, 0,0,0,0));
    t0.push_back(mk(0,1,0,0,0,0,1, 0,0,1,32'h8));
    for (int i = 0; i < 4; i++)
      t0.push_back(mk(0,0,0,0,0,0,1, 1,32'hC,0,0));
    t0.push_back(mk(0,1,0,0,0,0,1, 1,32'hC,0,0));
    t0.push_back(mk(0,1,0,0,0,0,1, 0,0,0,0));
    t0.push_back(mk(0,1,1,dat(32'hC),0,0,1, 0,0,0,0));
    for (int i = 0; i < 5; i++)
      t0.push_back(mk(0,1,0,0,0,0,0, 0,0,1,32'hC));
    t0.push_back(mk(0,1,0,0,0,0,1, 0,0,1,32'hC));
    t0.push_back(mk(1,1,0,0,0,0,1, 0,0,0,0));
    t0.push_back(mk(0,1,0,0,0,0,1, 1,32'h10,0,0));
    t0.push_back(mk(1,1,1,dat(32'h10),0,0,1, 0,0,0,0));
    t0.push_back(mk(1,1,0,0,0,0,1, 0,0,1,32'h10));
    t0.push_back(mk(0,1,0,0,0,0,1, 1,32'h14,0,0));
    t0.push_back(mk(0,1,0,0,1,32'h100,1, 0,0,0,0));
    t0.push_back(mk(0,1,1,dat(32'h14),0,0,1, 0,0,0,0));
    t0.push_back(mk(0,1,0,0,0,0,1, 1,32'h100,0,0));
    t0.push_back(mk(0,1,1,dat(32'h100),0,0,1, 0,0,0,0));
    t0.push_back(mk(0,1,0,0,0,0,1, 0,0,1,32'h100));
    t0.push_back(mk(0,1,0,0,0,0,1, 1,32'h104,0,0));
    t0.push_back(mk(0,1,1,dat(32'h104),0,0,1, 0,0,0,0));
    t0.push_back(mk(0,1,0,0,1,32'h203,1, 0,0,1,32'h104));
    t0.push_back(mk(0,1,0,0,1,32'h300,1, 1,32'h200,0,0));
    t0.push_back(mk(0,1,1,dat(32'h200),0,0,1, 0,0,0,0));
    t0.push_back(mk(0,0,1,32'hDEAD_BEEF,0,0,1, 1,32'h300,0,0));
    t0.push_back(mk(0,1,0,0,0,0,1, 1,32'h300,0,0));
    t0.push_back(mk(0,1,1,dat(32'h300),0,0,1, 0,0,0,0));
    t0.push_back(mk(0,1,0,0,1,32'h400,0, 0,0,1,32'h300));
    t0.push_back(mk(0,1,0,0,0,0,1, 1,32'h400,0,0));
    t0.push_back(mk(0,1,1,dat(32'h400),1,32'h503,1, 0,0,0,0));
    t0.push_back(mk(0,0,0,0,0,0,1, 1,32'h500,0,0));

    // ---- directed table for RESET_VECTOR = FFFF_FFFC ----
    t1.push_back(mk(0,1,0,0,0,0,1, 1,32'hFFFF_FFFC,0,0));
    t1.push_back(mk(0,1,1,dat(32'hFFFF_FFFC),0,0,1, 0,0,0,0));
    t1.push_back(mk(0,1,0,0,0,0,1, 0,0,1,32'hFFFF_FFFC));
    t1.push_back(mk(0,1,0,0,0,0,1, 1,32'h0,0,0));
    t1.push_back(mk(0,1,1,dat(32'h0),0,0,1, 0,0,0,0));
    t1.push_back(mk(0,1,0,0,0,0,1, 0,0,1,32'h0));
    t1.push_back(mk(0,1,0,0,0,0,1, 1,32'h4,0,0));

    reset = 1'b1; halt = 1'b0; rq_ready = 1'b0;
    rs_valid = 1'b0; rs_data = 32'h0; rd_valid = 1'b0;
    rd_pc = 32'h0; o_ready = 1'b0;
    reset_b = 1'b1; halt_b = 1'b0; rq_ready_b = 1'b0;
    rs_valid_b = 1'b0; rs_data_b = 32'h0; rd_valid_b = 1'b0;
    rd_pc_b = 32'h0; o_ready_b = 1'b0;

    repeat (3) @(negedge clk);
    rs_valid = 1'b1; rq_ready = 1'b1; o_ready = 1'b1;
    #1;
    chk("rst_rqv", rq_valid, 1'b0);
    chk("rst_addr", rq_addr, 32'h0);
    chk("rst_ov", o_valid, 1'b0);
    chk("rst_opc", o_pc, 32'h0);
    chk("rst_oin", o_instr, 32'h0);
    chk("rst_addr_b", rq_addr_b, 32'hFFFF_FFFC);
    chk("rst_ov_b", o_valid_b, 1'b0);

    @(negedge clk);
    reset = 1'b0; rs_valid = 1'b0; rq_ready = 1'b0;
    #1;
    chk("first_rqv", rq_valid, 1'b1);
    chk("first_addr", rq_addr, 32'h0);

    foreach (t0[i]) begin
      @(negedge clk);
      halt = t0[i].h; rq_ready = t0[i].rdy;
      rs_valid = t0[i].sv; rs_data = t0[i].sd;
      rd_valid = t0[i].dv; rd_pc = t0[i].dp;
      o_ready = t0[i].ordy;
      #1;
      chk($sformatf("t0[%0d].rqv", i), rq_valid, t0[i].e_rqv);
      if (t0[i].e_rqv)
        chk($sformatf("t0[%0d].addr", i), rq_addr, t0[i].e_addr);
      chk($sformatf("t0[%0d].ov", i), o_valid, t0[i].e_ov);
      if (t0[i].e_ov) begin
        chk($sformatf("t0[%0d].opc", i), o_pc, t0[i].e_opc);
        chk($sformatf("t0[%0d].oin", i), o_instr, t0[i].e_oin);
      end
    end

    // ---- wrap-around vector and reset during WAIT ----
    @(negedge clk);
    rq_ready = 1'b0; rs_valid = 1'b0; rd_valid = 1'b0;
    reset_b = 1'b0;
    foreach (t1[i]) begin
      @(negedge clk);
      halt_b = t1[i].h; rq_ready_b = t1[i].rdy;
      rs_valid_b = t1[i].sv; rs_data_b = t1[i].sd;
      rd_valid_b = t1[i].dv; rd_pc_b = t1[i].dp;
      o_ready_b = t1[i].ordy;
      #1;
      chk($sformatf("t1[%0d].rqv", i), rq_valid_b, t1[i].e_rqv);
      if (t1[i].e_rqv)
        chk($sformatf("t1[%0d].addr", i), rq_addr_b, t1[i].e_addr);
      chk($sformatf("t1[%0d].ov", i), o_valid_b, t1[i].e_ov);
      if (t1[i].e_ov) begin
        chk($sformatf("t1[%0d].opc", i), o_pc_b, t1[i].e_opc);
        chk($sformatf("t1[%0d].oin", i), o_instr_b, t1[i].e_oin);
      end
    end
    @(negedge clk);
    rq_ready_b = 1'b0;
    #2;
    reset_b = 1'b1;
    #1;
    chk("midrst_ov_b", o_valid_b, 1'b0);
    chk("midrst_rqv_b", rq_valid_b, 1'b0);
    chk("midrst_addr_b", rq_addr_b, 32'hFFFF_FFFC);
    @(negedge clk);
    reset_b = 1'b0;
    rs_valid_b = 1'b1; rs_data_b = dat(32'h4);
    #1;
    chk("restart_rqv_b", rq_valid_b, 1'b1);
    chk("restart_addr_b", rq_addr_b, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    chk("stale_resp_ov_b", o_valid_b, 1'b0);
    chk("stale_resp_addr_b", rq_addr_b, 32'hFFFF_FFFC);
    rs_valid_b = 1'b0;

    // ---- randomized run against the fetch-stream model ----
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    outst = 1'b0; lat = 0; oaddr = 32'h0;
    exp_pc = 32'h0; deliv = 0;
    p_rd = 1'b0; p_hold = 1'b0; p_rqw = 1'b0;
    p_opc = 32'h0; p_oin = 32'h0; p_addr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      halt     = ($urandom % 10) == 0;
      rq_ready = ($urandom % 3) != 0;
      o_ready  = ($urandom % 4) != 0;
      rd_valid = ($urandom % 20) == 0;
      rd_pc    = $urandom;
      if (outst) begin
        if (lat == 0) begin
          rs_valid = 1'b1; rs_data = dat(oaddr);
        end else begin
          rs_valid = 1'b0; rs_data = $urandom; lat--;
        end
      end else begin
        rs_valid = ($urandom % 8) == 0; rs_data = $urandom;
      end
      #1;
      if (p_rd) chk("ov_after_redirect", o_valid, 1'b0);
      if (p_hold) begin
        chk("hold_ov", o_valid, 1'b1);
        chk("hold_opc", o_pc, p_opc);
        chk("hold_oin", o_instr, p_oin);
      end
      if (p_rqw) chk("req_addr_stable", rq_addr, p_addr);
      if (halt) chk("halt_blocks", rq_valid, 1'b0);
      if (o_valid && o_ready) begin
        deliv++;
        chk("deliv_pc", o_pc, exp_pc);
        chk("deliv_instr", o_instr, dat(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      if (rq_valid && rq_ready) begin
        chk("one_outstanding", outst, 1'b0);
        if (!rd_valid) chk("req_addr", rq_addr, exp_pc);
      end
      if (outst && rs_valid) outst = 1'b0;
      if (rq_valid && rq_ready) begin
        outst = 1'b1;
        lat   = int'($urandom % 4);
        oaddr = rq_addr;
      end
      if (rd_valid) exp_pc = rd_pc & ~32'h3;
      p_rd   = rd_valid;
      p_hold = o_valid && !o_ready && !rd_valid;
      p_opc  = o_pc;
      p_oin  = o_instr;
      p_rqw  = rq_valid && !rq_ready && !rd_valid;
      p_addr = rq_addr;
    end
    chk("progress", 32'(deliv > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
